lcd_status_reader: RTL and testbench
====================================

# lcd_status_reader

Reads the HD44780 busy flag and address counter from the character LCD over the shared 4-bit bus (RS=0, RW=1). It is the read-side counterpart of the LCD write path: the display writer hands the bus to this block between commands, and this block returns BF/AC or, in wait mode, polls until the controller is ready. It sits beside the LCD writer under `top`, clocked by the scaled `clock`.

## Interface
Parameters:
- `SETUP_CYCLES`, 1: cycles of RS/RW setup before the first E rise (≥1).
- `E_HIGH_CYCLES`, 1: E high time per nibble (≥1).
- `E_LOW_CYCLES`, 1: E low time after each nibble (≥1); the second low phase doubles as hold time.
- `MAX_POLLS`, 255: wait-mode poll limit (1..255).

Ports:
- `clock` in 1: scaled system clock.
- `ResetN` in 1: asynchronous, active-low reset.
- `Start` in 1: request a read; sampled only in IDLE.
- `WaitReady` in 1: sampled with `Start`; 1 = repeat reads until BF=0.
- `Busy` out 1: transaction in progress (bus owned).
- `Done` out 1: one-cycle completion pulse.
- `BusyFlag` out 1: last BF read.
- `AddrCounter` out 7: last AC read.
- `Timeout` out 1: valid with `Done`; wait mode hit `MAX_POLLS` with BF still 1.
- `LCDE` out 1: enable strobe.
- `LCDRS` out 1: register select, always 0 while driving.
- `LCDRW` out 1: 1 during read, 0 otherwise.
- `LCDATIn` in 4: DB7..DB4 from the pad.
- `LCDATDrive` out 1: FPGA data-pad output enable for the writer; 0 whenever `LCDRW`=1.

## Operation
- States: IDLE, SETUP, HI1, LO1, HI2, LO2, DONE.
- IDLE: `Start`=1 → latch `WaitReady`, clear poll count, go SETUP; `Busy`=1 from next cycle.
- SETUP: `LCDRW`=1, `LCDRS`=0, `LCDE`=0, `LCDATDrive`=0 for `SETUP_CYCLES`.
- HI1: `LCDE`=1 for `E_HIGH_CYCLES`; on last cycle capture `LCDATIn[3]`→BF, `LCDATIn[2:0]`→AC[6:4].
- LO1: `LCDE`=0 for `E_LOW_CYCLES`.
- HI2: `LCDE`=1; on last cycle capture `LCDATIn[3:0]`→AC[3:0].
- LO2: `LCDE`=0, `LCDRW` held 1 for `E_LOW_CYCLES`. Then: wait mode and BF=1 and polls+1 < `MAX_POLLS` → increment poll count, go HI1 (RW stays 1, no new setup); else DONE.
- DONE: `LCDRW`=0, `Done`=1 for one cycle, update `BusyFlag`/`AddrCounter` outputs, `Timeout` = wait mode and BF=1; return IDLE, `Busy`=0.
- Outputs `BusyFlag`/`AddrCounter` change only in DONE; they hold between transactions.
- `Start` outside IDLE ignored (no queueing). `Start` held high in IDLE after DONE starts a new read.
- Single-read mode never sets `Timeout`.
- Poll counter 8 bits, saturates conceptually at `MAX_POLLS`; never wraps.

## Timing
- Reset values: `Busy`=0, `Done`=0, `BusyFlag`=0, `AddrCounter`=0, `Timeout`=0, `LCDE`=0, `LCDRS`=0, `LCDRW`=0, `LCDATDrive`=1; state IDLE.
- `ResetN` low mid-transaction: immediately all outputs to reset values, `LCDE` dropped without completing the nibble; no `Done`.
- All LCD outputs registered; no combinational path from `LCDATIn` to outputs.
- Single read latency: `Done` high in cycle S+2H+2L+1 after `Start` sample edge (defaults: 6).
- Each extra poll adds 2H+2L cycles.
- `LCDRW` rises with SETUP entry, falls on DONE entry; `LCDATDrive` is its inverse, so drive never overlaps read.

## Structure
- Package `lcd_pkg`: state enum, RS/RW constants, BF bit index (3), AC nibble split constants; shared with the LCD writer.
- Sub-module `lcd_phase_timer`: loadable down-counter with `expire` output, width from max of the three timing parameters; the FSM loads it on each state entry.

## Test plan
- Single read, pad model returns 0x8 then 0x5 (BF=1, AC=0x05): `Done` at cycle 6, `BusyFlag`=1, `AddrCounter`=0x05, `Timeout`=0.
- Wait mode, BF=1 for 3 reads then 0x2/0xA: 4 read pairs, `Done` at 6+3×4=18, `AddrCounter`=0x2A, `Timeout`=0.
- Wait mode, `MAX_POLLS`=4, BF stuck 1: exactly 4 E-pulse pairs, `Done` with `Timeout`=1, `BusyFlag`=1.
- `Start` pulsed during HI2: ignored; exactly one `Done`; `Start` held high: back-to-back reads with one IDLE cycle between.
- `ResetN` low during HI1: `LCDE`, `LCDRW`, `Busy` to 0 and `LCDATDrive` to 1 asynchronously; no `Done`; next `Start` completes normally.
- Timing params S=3, H=2, L=4: E high exactly 2 cycles per nibble, `Done` at 3+4+8+1=16; assert `LCDATDrive`=0 whenever `LCDRW`=1.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared HD44780 bus definitions for the LCD status reader and writer:
// FSM states, RS/RW encodings and the busy-flag/address-counter nibble layout.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_HI1,
    ST_LO1,
    ST_HI2,
    ST_LO2,
    ST_DONE
  } lcd_state_e;

  localparam logic LCD_RS_CMD   = 1'b0;
  localparam logic LCD_RS_DATA  = 1'b1;
  localparam logic LCD_RW_WRITE = 1'b0;
  localparam logic LCD_RW_READ  = 1'b1;

  // First nibble carries BF in DB7 and AC[6:4] in DB6..DB4; second nibble is AC[3:0].
  localparam int LCD_BF_BIT   = 3;
  localparam int LCD_AC_HI_W  = 3;
  localparam int LCD_AC_LO_W  = 4;
  localparam int LCD_AC_W     = LCD_AC_HI_W + LCD_AC_LO_W;

  function automatic int lcd_max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/lcd_phase_timer.sv
// Loadable down-counter timing one bus phase; expire_o is high on the
// last cycle of the loaded interval.
module lcd_phase_timer #(
  parameter int W = 2
) (
  input  logic         clock,
  input  logic         ResetN,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         expire_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)            cnt_d = load_val_i;
    else if (cnt_q != '0)  cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clock or negedge ResetN) begin
    if (!ResetN) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/lcd_status_reader.sv
// Reads HD44780 BF/AC over the 4-bit bus as two E-strobed nibbles; in wait
// mode re-reads (without a new setup phase) until BF clears or the poll limit.
module lcd_status_reader
  import lcd_pkg::*;
#(
  parameter int SETUP_CYCLES  = 1,
  parameter int E_HIGH_CYCLES = 1,
  parameter int E_LOW_CYCLES  = 1,
  parameter int MAX_POLLS     = 255
) (
  input  logic       clock,
  input  logic       ResetN,
  input  logic       Start,
  input  logic       WaitReady,
  output logic       Busy,
  output logic       Done,
  output logic       BusyFlag,
  output logic [6:0] AddrCounter,
  output logic       Timeout,
  output logic       LCDE,
  output logic       LCDRS,
  output logic       LCDRW,
  input  logic [3:0] LCDATIn,
  output logic       LCDATDrive
);

  localparam int TW = $clog2(lcd_max3(SETUP_CYCLES, E_HIGH_CYCLES, E_LOW_CYCLES) + 1);

  lcd_state_e state_q, state_d;
  logic                   wait_q, wait_d;
  logic [7:0]             polls_q, polls_d;
  logic                   bf_q, bf_d;
  logic [LCD_AC_HI_W-1:0] ac_hi_q, ac_hi_d;
  logic [LCD_AC_LO_W-1:0] ac_lo_q, ac_lo_d;

  logic                   e_q, e_d, rw_q, rw_d, busy_q, busy_d, done_q, done_d;
  logic                   bf_out_q, bf_out_d, to_q, to_d;
  logic [LCD_AC_W-1:0]    ac_out_q, ac_out_d;

  logic          tmr_load, tmr_expire;
  logic [TW-1:0] tmr_val;

  lcd_phase_timer #(.W(TW)) u_timer (
    .clock      (clock),
    .ResetN     (ResetN),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .expire_o   (tmr_expire)
  );

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    polls_d = polls_q;
    bf_d    = bf_q;
    ac_hi_d = ac_hi_q;
    ac_lo_d = ac_lo_q;
    unique case (state_q)
      ST_IDLE: if (Start) begin
        state_d = ST_SETUP;
        wait_d  = WaitReady;
        polls_d = '0;
      end
      ST_SETUP: if (tmr_expire) state_d = ST_HI1;
      ST_HI1: if (tmr_expire) begin
        bf_d    = LCDATIn[LCD_BF_BIT];
        ac_hi_d = LCDATIn[LCD_AC_HI_W-1:0];
        state_d = ST_LO1;
      end
      ST_LO1: if (tmr_expire) state_d = ST_HI2;
      ST_HI2: if (tmr_expire) begin
        ac_lo_d = LCDATIn;
        state_d = ST_LO2;
      end
      // Polling loops straight back to HI1: RW stays asserted, so no re-setup.
      ST_LO2: if (tmr_expire) begin
        if (wait_q && bf_q && ({1'b0, polls_q} + 9'd1 < 9'(MAX_POLLS))) begin
          polls_d = polls_q + 8'd1;
          state_d = ST_HI1;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    tmr_load = (state_d != state_q);
    tmr_val  = '0;
    unique case (state_d)
      ST_SETUP:       tmr_val = TW'(SETUP_CYCLES - 1);
      ST_HI1, ST_HI2: tmr_val = TW'(E_HIGH_CYCLES - 1);
      ST_LO1, ST_LO2: tmr_val = TW'(E_LOW_CYCLES - 1);
      default:        tmr_val = '0;
    endcase
  end

  // Bus and handshake outputs are decoded from the next state and registered.
  always_comb begin
    e_d      = (state_d == ST_HI1) || (state_d == ST_HI2);
    rw_d     = (state_d != ST_IDLE) && (state_d != ST_DONE);
    busy_d   = (state_d != ST_IDLE);
    done_d   = (state_d == ST_DONE);
    bf_out_d = bf_out_q;
    ac_out_d = ac_out_q;
    to_d     = to_q;
    if (state_d == ST_DONE && state_q != ST_DONE) begin
      bf_out_d = bf_q;
      ac_out_d = {ac_hi_q, ac_lo_q};
      to_d     = wait_q && bf_q;
    end
  end

  always_ff @(posedge clock or negedge ResetN) begin
    if (!ResetN) begin
      state_q  <= ST_IDLE;
      wait_q   <= 1'b0;
      polls_q  <= '0;
      bf_q     <= 1'b0;
      ac_hi_q  <= '0;
      ac_lo_q  <= '0;
      e_q      <= 1'b0;
      rw_q     <= LCD_RW_WRITE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      bf_out_q <= 1'b0;
      ac_out_q <= '0;
      to_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      polls_q  <= polls_d;
      bf_q     <= bf_d;
      ac_hi_q  <= ac_hi_d;
      ac_lo_q  <= ac_lo_d;
      e_q      <= e_d;
      rw_q     <= rw_d ? LCD_RW_READ : LCD_RW_WRITE;
      busy_q   <= busy_d;
      done_q   <= done_d;
      bf_out_q <= bf_out_d;
      ac_out_q <= ac_out_d;
      to_q     <= to_d;
    end
  end

  assign Busy        = busy_q;
  assign Done        = done_q;
  assign BusyFlag    = bf_out_q;
  assign AddrCounter = ac_out_q;
  assign Timeout     = to_q;
  assign LCDE        = e_q;
  assign LCDRS       = LCD_RS_CMD;
  assign LCDRW       = rw_q;
  assign LCDATDrive  = ~rw_q;

endmodule

// File: tb/tb_lcd_status_reader.sv
// Bench for lcd_status_reader: two instances (default timing with 4-poll limit,
// and S=3/H=2/L=4) checked every cycle against a transaction-level model.
module tb_lcd_status_reader;

  localparam int PS [2] = '{1, 3};
  localparam int PH [2] = '{1, 2};
  localparam int PL [2] = '{1, 4};
  localparam int PM [2] = '{4, 255};

  logic       clock = 1'b0;
  logic       ResetN;
  logic [1:0] start, waitr, busy, done, bfo, to, lcde, lcdrs, lcdrw, drive;
  logic [6:0] aco [2];
  logic [3:0] dat [2];

  always #5 clock = ~clock;

  lcd_status_reader #(.MAX_POLLS(4)) u_a (
    .clock(clock), .ResetN(ResetN), .Start(start[0]), .WaitReady(waitr[0]),
    .Busy(busy[0]), .Done(done[0]), .BusyFlag(bfo[0]), .AddrCounter(aco[0]),
    .Timeout(to[0]), .LCDE(lcde[0]), .LCDRS(lcdrs[0]), .LCDRW(lcdrw[0]),
    .LCDATIn(dat[0]), .LCDATDrive(drive[0]));

  lcd_status_reader #(.SETUP_CYCLES(3), .E_HIGH_CYCLES(2), .E_LOW_CYCLES(4)) u_b (
    .clock(clock), .ResetN(ResetN), .Start(start[1]), .WaitReady(waitr[1]),
    .Busy(busy[1]), .Done(done[1]), .BusyFlag(bfo[1]), .AddrCounter(aco[1]),
    .Timeout(to[1]), .LCDE(lcde[1]), .LCDRS(lcdrs[1]), .LCDRW(lcdrw[1]),
    .LCDATIn(dat[1]), .LCDATDrive(drive[1]));

  int checks = 0, errors = 0, tick = 0;

  // Pad model: each E rise presents the next nibble of the per-instance script.
  logic [3:0] nibs [2][64];
  int pc [2] = '{0, 0};
  always @(posedge lcde[0]) begin dat[0] = nibs[0][pc[0] % 64]; pc[0]++; end
  always @(posedge lcde[1]) begin dat[1] = nibs[1][pc[1] % 64]; pc[1]++; end

  bit         armed [2];
  int         cyc [2], expN [2], expR [2], base [2], erun [2];
  logic       exp_bf [2], exp_to [2], held_bf [2], held_to [2];
  logic [6:0] exp_ac [2], held_ac [2];
  int         done_cnt [2], done_at [2], got_cyc [2], got_pulses [2];
  logic       got_bf [2], got_to [2];
  logic [6:0] got_ac [2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Transaction model: reads consume nibble pairs until single mode, BF=0 or the poll limit.
  task automatic model(input int d, input bit w, input int b);
    logic [3:0] hi, lo;
    int r;
    r = 0; hi = '0; lo = '0;
    for (int k = 0; k < 256; k++) begin
      hi = nibs[d][(b + 2*r) % 64];
      lo = nibs[d][(b + 2*r + 1) % 64];
      r++;
      if (!w || !hi[3] || r >= PM[d]) break;
    end
    exp_bf[d] = hi[3];
    exp_ac[d] = {hi[2:0], lo};
    exp_to[d] = w && hi[3];
    expR[d]   = r;
    expN[d]   = PS[d] + 2*PH[d] + 2*PL[d] + 1 + (r - 1) * (2*PH[d] + 2*PL[d]);
    base[d]   = b;
  endtask

  // Cycle 1 is the cycle following the edge that samples Start.
  always @(negedge clock) begin
    tick++;
    if (ResetN) begin
      for (int d = 0; d < 2; d++) begin
        chk("drive_inv", drive[d], !lcdrw[d]);
        chk("rs_zero", lcdrs[d], 0);
        if (lcde[d]) erun[d]++;
        else if (erun[d] > 0) begin chk("e_high_len", erun[d], PH[d]); erun[d] = 0; end
        if (armed[d]) cyc[d]++;
        chk("busy", busy[d], armed[d] && cyc[d] >= 1);
        chk("done", done[d], armed[d] && cyc[d] == expN[d]);
        if (done[d]) begin
          done_cnt[d]++; done_at[d] = tick; got_cyc[d] = cyc[d];
          got_bf[d] = bfo[d]; got_ac[d] = aco[d]; got_to[d] = to[d];
          got_pulses[d] = pc[d] - base[d];
        end
        if (armed[d] && cyc[d] == expN[d]) begin
          chk("bf", bfo[d], exp_bf[d]);
          chk("ac", aco[d], exp_ac[d]);
          chk("timeout", to[d], exp_to[d]);
          chk("e_pulses", pc[d] - base[d], 2 * expR[d]);
          held_bf[d] = exp_bf[d]; held_ac[d] = exp_ac[d]; held_to[d] = exp_to[d];
          if (start[d]) begin model(d, waitr[d], pc[d]); cyc[d] = -1; end
          else armed[d] = 0;
        end else begin
          chk("bf_hold", bfo[d], held_bf[d]);
          chk("ac_hold", aco[d], held_ac[d]);
          chk("to_hold", to[d], held_to[d]);
        end
      end
    end
  end

  task automatic put2(input int d, input int off, input logic [3:0] a, input logic [3:0] b);
    nibs[d][(pc[d] + off) % 64]     = a;
    nibs[d][(pc[d] + off + 1) % 64] = b;
  endtask

  task automatic go(input int d, input bit w);
    @(negedge clock);
    start[d] = 1'b1; waitr[d] = w;
    @(posedge clock); #1;
    start[d] = 1'b0;
    model(d, w, pc[d]);
    cyc[d] = 0; armed[d] = 1;
  endtask

  task automatic finish_rd(input int d);
    for (int i = 0; i < 300 && armed[d]; i++) @(posedge clock);
    chk("read_completes", armed[d], 0);
    armed[d] = 0;
  endtask

  task automatic chk_reset_outs(input int d);
    chk("rst_busy", busy[d], 0);   chk("rst_done", done[d], 0);
    chk("rst_bf", bfo[d], 0);      chk("rst_ac", aco[d], 0);
    chk("rst_to", to[d], 0);       chk("rst_e", lcde[d], 0);
    chk("rst_rw", lcdrw[d], 0);    chk("rst_drive", drive[d], 1);
  endtask

  int c0, t_first;

  initial begin
    ResetN = 1'b0; start = '0; waitr = '0;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 64; i++) nibs[d][i] = 4'h0;
      armed[d] = 0; cyc[d] = 0; erun[d] = 0; done_cnt[d] = 0;
      held_bf[d] = 0; held_ac[d] = '0; held_to[d] = 0;
    end
    #3;
    chk_reset_outs(0); chk_reset_outs(1);
    repeat (2) @(posedge clock);
    #3 ResetN = 1'b1;

    // Single read: BF=1, AC=0x05
    put2(0, 0, 4'h8, 4'h5);
    go(0, 0); finish_rd(0);
    chk("t1_cyc", got_cyc[0], 6);      chk("t1_bf", got_bf[0], 1);
    chk("t1_ac", got_ac[0], 7'h05);    chk("t1_to", got_to[0], 0);
    chk("t1_pulses", got_pulses[0], 2);

    // Wait mode, busy for three reads then 0x2/0xA
    put2(0, 0, 4'h8, 4'h0); put2(0, 2, 4'h9, 4'h1);
    put2(0, 4, 4'h8, 4'h3); put2(0, 6, 4'h2, 4'hA);
    go(0, 1); finish_rd(0);
    chk("t2_cyc", got_cyc[0], 18);     chk("t2_ac", got_ac[0], 7'h2A);
    chk("t2_bf", got_bf[0], 0);        chk("t2_to", got_to[0], 0);
    chk("t2_pulses", got_pulses[0], 8);

    // Wait mode, BF stuck high: limit of 4 polls
    for (int i = 0; i < 6; i++) put2(0, 2*i, 4'h8, 4'h1);
    go(0, 1); finish_rd(0);
    chk("t3_cyc", got_cyc[0], 18);     chk("t3_to", got_to[0], 1);
    chk("t3_bf", got_bf[0], 1);        chk("t3_pulses", got_pulses[0], 8);

    // Start pulsed during HI2 is ignored
    put2(0, 0, 4'h1, 4'h4);
    c0 = done_cnt[0];
    go(0, 0);
    repeat (3) @(posedge clock);
    #1 start[0] = 1'b1;
    @(posedge clock); #1 start[0] = 1'b0;
    finish_rd(0);
    repeat (10) @(posedge clock);
    chk("t4_one_done", done_cnt[0] - c0, 1);
    chk("t4_ac", got_ac[0], 7'h14);

    // Start held high: back-to-back reads, one IDLE cycle between
    put2(0, 0, 4'h0, 4'h7); put2(0, 2, 4'h1, 4'h2);
    c0 = done_cnt[0];
    @(negedge clock); start[0] = 1'b1; waitr[0] = 1'b0;
    @(posedge clock); #1;
    model(0, 0, pc[0]); cyc[0] = 0; armed[0] = 1;
    for (int i = 0; i < 50 && done_cnt[0] == c0; i++) @(posedge clock);
    t_first = done_at[0];
    @(posedge clock); @(posedge clock); #1 start[0] = 1'b0;
    finish_rd(0);
    repeat (10) @(posedge clock);
    chk("t5_two_done", done_cnt[0] - c0, 2);
    chk("t5_gap", done_at[0] - t_first, 7);
    chk("t5_ac", got_ac[0], 7'h12);

    // Reset during HI1: everything back to reset values, no Done
    put2(0, 0, 4'h3, 4'h3);
    c0 = done_cnt[0];
    go(0, 0);
    @(posedge clock); #2;
    chk("t6_in_hi1", lcde[0], 1);
    ResetN = 1'b0;
    #1;
    chk_reset_outs(0);
    for (int d = 0; d < 2; d++) begin
      armed[d] = 0; erun[d] = 0; held_bf[d] = 0; held_ac[d] = '0; held_to[d] = 0;
    end
    @(posedge clock); #3 ResetN = 1'b1;
    put2(0, 0, 4'h5, 4'hE);
    go(0, 0); finish_rd(0);
    chk("t6_one_done", done_cnt[0] - c0, 1);
    chk("t6_cyc", got_cyc[0], 6);      chk("t6_ac", got_ac[0], 7'h5E);
    chk("t6_bf", got_bf[0], 0);

    // Slow timing instance: S=3, H=2, L=4
    put2(1, 0, 4'hC, 4'h7);
    go(1, 0); finish_rd(1);
    chk("t7_cyc", got_cyc[1], 16);     chk("t7_bf", got_bf[1], 1);
    chk("t7_ac", got_ac[1], 7'h47);    chk("t7_pulses", got_pulses[1], 2);

    put2(1, 0, 4'h8, 4'h0); put2(1, 2, 4'h1, 4'h9);
    go(1, 1); finish_rd(1);
    chk("t8_cyc", got_cyc[1], 28);     chk("t8_ac", got_ac[1], 7'h19);
    chk("t8_to", got_to[1], 0);        chk("t8_pulses", got_pulses[1], 4);

    repeat (5) @(posedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
